// File: rtl/home_sensor_frontend_if.sv
// Signal bundle between home_sensor_frontend (master) and the board / FSM side (slave).
interface home_sensor_frontend_if;
   logic [3:0] raw_sensors;
   logic       adc_miso;
   logic       adc_cs_n;
   logic       adc_sclk;
   logic [3:0] sensors;
   logic [5:0] temp;
   logic       temp_valid;
   logic       sensor_change;

   modport master (
      input  raw_sensors, adc_miso,
      output adc_cs_n, adc_sclk, sensors, temp, temp_valid, sensor_change
   );

   modport slave (
      output raw_sensors, adc_miso,
      input  adc_cs_n, adc_sclk, sensors, temp, temp_valid, sensor_change
   );
endinterface

// File: rtl/home_sensor_frontend.sv
// Sensor input front end: debounced switch levels plus periodic 6-bit serial ADC temperature read.
module home_sensor_frontend #(
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter int         SCLK_DIV        = 4,
   parameter int         SAMPLE_PERIOD   = 100,
   parameter logic [5:0] TEMP_RESET      = 6'd15
) (
   input  logic                   clk,
   input  logic                   rst,
   home_sensor_frontend_if.master bus
);
   localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [7:0]    DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      SCLK_LO = 3'd2,
      SCLK_HI = 3'd3,
      DONE    = 3'd4
   } adc_state_t;

   logic [3:0]    sync1_r, sync2_r, sensors_r;
   logic [7:0]    deb_cnt_r [0:3];
   logic [3:0]    deb_hit_s;
   logic          sensor_change_r;

   adc_state_t    state_r, state_next_s;
   logic [PW-1:0] period_r;
   logic [DW-1:0] div_r;
   logic [2:0]    bit_r;
   logic [5:0]    shift_r, temp_r;
   logic          cs_n_r, sclk_r, temp_valid_r;
   logic          cs_n_s, sclk_s, valid_s, sample_s;
   logic          start_s, div_last_s;

   assign start_s    = (period_r == PER_LAST);
   assign div_last_s = (div_r == DIV_LAST);

   // A channel commits when it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      deb_hit_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         deb_hit_s[i] = (sync2_r[i] != sensors_r[i]) && (deb_cnt_r[i] == DEB_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r         <= 4'b0000;
         sync2_r         <= 4'b0000;
         sensors_r       <= 4'b0000;
         sensor_change_r <= 1'b0;
         for (int i = 0; i < 4; i++) deb_cnt_r[i] <= 8'd0;
      end else begin
         sync1_r         <= bus.raw_sensors;
         sync2_r         <= sync1_r;
         sensor_change_r <= |deb_hit_s;
         for (int i = 0; i < 4; i++) begin
            if (deb_hit_s[i]) begin
               sensors_r[i] <= sync2_r[i];
               deb_cnt_r[i] <= 8'd0;
            end else if (sync2_r[i] != sensors_r[i]) begin
               deb_cnt_r[i] <= deb_cnt_r[i] + 8'd1;
            end else begin
               deb_cnt_r[i] <= 8'd0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_next_s;
   end

   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    if (start_s) state_next_s = SETUP;   else state_next_s = IDLE;
         SETUP:   if (div_last_s) state_next_s = SCLK_HI; else state_next_s = SETUP;
         SCLK_HI: if (div_last_s) state_next_s = SCLK_LO; else state_next_s = SCLK_HI;
         SCLK_LO: begin
            if (div_last_s) begin
               if (bit_r == 3'd5) state_next_s = DONE;
               else               state_next_s = SCLK_HI;
            end else begin
               state_next_s = SCLK_LO;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Decoded from the next state so the registered pins line up with the state register.
   always_comb begin
      cs_n_s   = 1'b1;
      sclk_s   = 1'b0;
      valid_s  = 1'b0;
      sample_s = 1'b0;
      case (state_next_s)
         SETUP, SCLK_LO: cs_n_s = 1'b0;
         SCLK_HI: begin
            cs_n_s   = 1'b0;
            sclk_s   = 1'b1;
            sample_s = (state_r != SCLK_HI);
         end
         DONE:    valid_s = 1'b1;
         default: cs_n_s  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_r     <= {PW{1'b0}};
         div_r        <= {DW{1'b0}};
         bit_r        <= 3'd0;
         shift_r      <= 6'd0;
         temp_r       <= TEMP_RESET;
         temp_valid_r <= 1'b0;
         cs_n_r       <= 1'b1;
         sclk_r       <= 1'b0;
      end else begin
         if (start_s) period_r <= {PW{1'b0}};
         else         period_r <= period_r + PW'(1);
         if ((state_next_s != state_r) || (state_r == IDLE)) div_r <= {DW{1'b0}};
         else                                                div_r <= div_r + DW'(1);
         if (state_r == IDLE)                                     bit_r <= 3'd0;
         else if ((state_r == SCLK_LO) && (state_next_s == SCLK_HI)) bit_r <= bit_r + 3'd1;
         else                                                     bit_r <= bit_r;
         if (sample_s) shift_r <= {shift_r[4:0], bus.adc_miso};
         else          shift_r <= shift_r;
         if (valid_s)  temp_r  <= shift_r;
         else          temp_r  <= temp_r;
         temp_valid_r <= valid_s;
         cs_n_r       <= cs_n_s;
         sclk_r       <= sclk_s;
      end
   end

   assign bus.sensors       = sensors_r;
   assign bus.sensor_change = sensor_change_r;
   assign bus.temp          = temp_r;
   assign bus.temp_valid    = temp_valid_r;
   assign bus.adc_cs_n      = cs_n_r;
   assign bus.adc_sclk      = sclk_r;
endmodule

// File: tb/tb_home_sensor_frontend.sv
// Directed bench for home_sensor_frontend: debounce timing, glitch rejection and serial ADC reads.
module tb_home_sensor_frontend;
   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   int         checks    = 0;
   int         errors    = 0;
   logic [5:0] adc_data  = 6'd0;
   logic [2:0] bit_idx   = 3'd0;
   logic       prev_sclk = 1'b0;

   home_sensor_frontend_if bus ();

   home_sensor_frontend #(
      .DEBOUNCE_CYCLES(4),
      .SCLK_DIV(4),
      .SAMPLE_PERIOD(100),
      .TEMP_RESET(6'd15)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // ADC model: MSB presented once CS falls, next bit after each SCLK rising edge.
   always @(negedge clk) begin
      if (bus.adc_cs_n !== 1'b0) bit_idx = 3'd0;
      else if (bus.adc_sclk === 1'b1 && prev_sclk === 1'b0) bit_idx = bit_idx + 3'd1;
      prev_sclk = bus.adc_sclk;
      bus.adc_miso = (bit_idx < 3'd6) ? adc_data[3'd5 - bit_idx] : 1'b0;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic watch_sensors(input logic [3:0] target, input int cycles,
                                output int at_cycle, output int pulses, output int pulse_cycle);
      at_cycle = -1;
      pulses = 0;
      pulse_cycle = -1;
      for (int k = 1; k <= cycles; k++) begin
         tick(1);
         if (bus.sensors === target && at_cycle < 0) at_cycle = k;
         if (bus.sensor_change === 1'b1) begin
            pulses++;
            pulse_cycle = k;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      int pulses;
      do_reset();
      checks++; if (bus.sensors !== 4'd0) begin errors++; $display("FAIL reset_sensors: got %0d expected 0", bus.sensors); end
      checks++; if (bus.temp !== 6'd15) begin errors++; $display("FAIL reset_temp: got %0d expected 15", bus.temp); end
      checks++; if (bus.adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", bus.adc_cs_n); end
      checks++; if (bus.adc_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", bus.adc_sclk); end
      checks++; if (bus.temp_valid !== 1'b0) begin errors++; $display("FAIL reset_temp_valid: got %b expected 0", bus.temp_valid); end
      checks++; if (bus.sensor_change !== 1'b0) begin errors++; $display("FAIL reset_sensor_change: got %b expected 0", bus.sensor_change); end
      n = 0;
      pulses = 0;
      while (bus.adc_cs_n !== 1'b0 && n < 200) begin
         tick(1);
         n++;
         if (bus.temp_valid === 1'b1 || bus.sensor_change === 1'b1) pulses++;
      end
      checks++; if (n !== 100) begin errors++; $display("FAIL first_cs_fall: got %0d cycles expected 100", n); end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_no_pulses: got %0d expected 0", pulses); end
   endtask

   task automatic test_door_edge();
      int at, pulses, pc;
      do_reset();
      bus.raw_sensors = 4'b0001;
      watch_sensors(4'b0001, 10, at, pulses, pc);
      checks++; if (at !== 6) begin errors++; $display("FAIL door_rise_latency: got %0d expected 6", at); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL door_rise_pulses: got %0d expected 1", pulses); end
      checks++; if (pc !== 6) begin errors++; $display("FAIL door_rise_pulse_cycle: got %0d expected 6", pc); end
      bus.raw_sensors = 4'b0000;
      watch_sensors(4'b0000, 10, at, pulses, pc);
      checks++; if (at !== 6) begin errors++; $display("FAIL door_fall_latency: got %0d expected 6", at); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL door_fall_pulses: got %0d expected 1", pulses); end
      checks++; if (pc !== 6) begin errors++; $display("FAIL door_fall_pulse_cycle: got %0d expected 6", pc); end
   endtask

   task automatic test_glitch();
      int at, pulses, pc;
      do_reset();
      bus.raw_sensors = 4'b0100;
      tick(3);
      bus.raw_sensors = 4'b0000;
      watch_sensors(4'b0100, 12, at, pulses, pc);
      checks++; if (at !== -1) begin errors++; $display("FAIL glitch_sensors: got change at %0d expected none", at); end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
      checks++; if (bus.sensors !== 4'd0) begin errors++; $display("FAIL glitch_final: got %0d expected 0", bus.sensors); end
      bus.raw_sensors = 4'b1010;
      watch_sensors(4'b1010, 10, at, pulses, pc);
      checks++; if (at !== 6) begin errors++; $display("FAIL pair_latency: got %0d expected 6", at); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL pair_pulses: got %0d expected 1", pulses); end
      checks++; if (pc !== 6) begin errors++; $display("FAIL pair_pulse_cycle: got %0d expected 6", pc); end
      bus.raw_sensors = 4'b0000;
   endtask

   task automatic test_adc_read();
      int n, low, rises;
      logic prev;
      do_reset();
      adc_data = 6'b000111;
      n = 0;
      while (bus.adc_cs_n !== 1'b0 && n < 200) begin tick(1); n++; end
      checks++; if (n !== 100) begin errors++; $display("FAIL adc_start: got %0d cycles expected 100", n); end
      low = 1;
      rises = 0;
      prev = bus.adc_sclk;
      while (bus.adc_cs_n === 1'b0 && low < 200) begin
         tick(1);
         if (bus.adc_cs_n === 1'b0) low++;
         if (bus.adc_sclk === 1'b1 && prev === 1'b0) rises++;
         prev = bus.adc_sclk;
      end
      checks++; if (low !== 52) begin errors++; $display("FAIL adc_cs_low: got %0d cycles expected 52", low); end
      checks++; if (rises !== 6) begin errors++; $display("FAIL adc_sclk_rises: got %0d expected 6", rises); end
      checks++; if (bus.temp_valid !== 1'b1) begin errors++; $display("FAIL adc_valid: got %b expected 1", bus.temp_valid); end
      checks++; if (bus.temp !== 6'd7) begin errors++; $display("FAIL adc_temp: got %0d expected 7", bus.temp); end
      tick(1);
      checks++; if (bus.temp_valid !== 1'b0) begin errors++; $display("FAIL adc_valid_width: got %b expected 0", bus.temp_valid); end
      checks++; if (bus.temp !== 6'd7) begin errors++; $display("FAIL adc_temp_hold: got %0d expected 7", bus.temp); end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      adc_data = 6'd45;
      n = 0;
      while (bus.temp_valid !== 1'b1 && n < 300) begin tick(1); n++; end
      checks++; if (n !== 152) begin errors++; $display("FAIL b2b_first_valid: got %0d cycles expected 152", n); end
      checks++; if (bus.temp !== 6'd45) begin errors++; $display("FAIL b2b_temp_45: got %0d expected 45", bus.temp); end
      adc_data = 6'd20;
      tick(1);
      n = 1;
      while (bus.temp_valid !== 1'b1 && n < 300) begin tick(1); n++; end
      checks++; if (n !== 100) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 100", n); end
      checks++; if (bus.temp !== 6'd20) begin errors++; $display("FAIL b2b_temp_20: got %0d expected 20", bus.temp); end
   endtask

   task automatic test_abort();
      int n, rises, cs_fall;
      logic prev;
      do_reset();
      adc_data = 6'b101010;
      rises = 0;
      n = 0;
      prev = bus.adc_sclk;
      while (rises < 3 && n < 300) begin
         tick(1);
         n++;
         if (bus.adc_sclk === 1'b1 && prev === 1'b0) rises++;
         prev = bus.adc_sclk;
      end
      rst = 1'b1;
      tick(1);
      checks++; if (bus.adc_cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs_n: got %b expected 1", bus.adc_cs_n); end
      checks++; if (bus.adc_sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", bus.adc_sclk); end
      checks++; if (bus.temp !== 6'd15) begin errors++; $display("FAIL abort_temp: got %0d expected 15", bus.temp); end
      checks++; if (bus.temp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", bus.temp_valid); end
      rst = 1'b0;
      n = 0;
      cs_fall = -1;
      while (bus.temp_valid !== 1'b1 && n < 300) begin
         tick(1);
         n++;
         if (bus.adc_cs_n === 1'b0 && cs_fall < 0) cs_fall = n;
      end
      checks++; if (cs_fall !== 100) begin errors++; $display("FAIL abort_restart_cs: got %0d cycles expected 100", cs_fall); end
      checks++; if (n !== 152) begin errors++; $display("FAIL abort_restart_valid: got %0d cycles expected 152", n); end
      checks++; if (bus.temp !== 6'd42) begin errors++; $display("FAIL abort_restart_temp: got %0d expected 42", bus.temp); end
   endtask

   initial begin
      bus.raw_sensors = 4'b0000;
      test_reset();
      test_door_edge();
      test_glitch();
      test_adc_read();
      test_back_to_back();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached with %0d checks done, expected completion", checks);
      $fatal(1, "watchdog expired");
   end
endmodule
